// File: rtl/voting_machine_n.sv
// N-candidate voting machine: qualifies held button presses, allows one vote
// per ballot, keeps saturating tallies, and shows a live winner/tie result.
//
// Ports:
//   clk      - system clock; all state updates on the rising edge
//   reset    - asynchronous active-low clear of all state
//   mode     - 0 = vote mode, 1 = result mode
//   button   - raw candidate buttons, active-high, synchronous to clk
//   sel      - candidate whose tally is shown on led in result mode
//   led      - vote mode: one-hot of the accepted candidate while locked;
//              result mode: registered tally[sel]
//   vote_ack - one-cycle pulse when a vote is accepted and counted
//   vote_err - one-cycle pulse when simultaneous presses are rejected
//   winner   - index of the highest tally, lowest index on a tie
//   tie      - two or more candidates share the highest tally
//   sat      - sticky flag: some tally has reached its maximum value
`default_nettype none

module voting_machine_n #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int HOLD_CYC = 10,
    parameter int LOCK_CYC = 100,
    localparam int SEL_W   = $clog2(NUM_CAND)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mode,
    input  logic [NUM_CAND-1:0] button,
    input  logic [SEL_W-1:0]    sel,
    output logic [CNT_W-1:0]    led,
    output logic                vote_ack,
    output logic                vote_err,
    output logic [SEL_W-1:0]    winner,
    output logic                tie,
    output logic                sat
);

    localparam int QW = $clog2(HOLD_CYC + 1);
    localparam int LW = $clog2(LOCK_CYC + 1);
    localparam logic [CNT_W-1:0] TMAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_LOCK, S_WAIT} state_t;

    state_t            r_state;
    state_t            w_state_n;
    logic [QW-1:0]     r_q [NUM_CAND];
    logic [CNT_W-1:0]  r_tally [NUM_CAND];
    logic [LW-1:0]     r_lock;
    logic [LW-1:0]     w_lock_n;
    logic [SEL_W-1:0]  r_cand;
    logic [CNT_W-1:0]  r_res;
    logic [SEL_W-1:0]  r_winner;
    logic              r_tie;
    logic              r_sat;
    logic              r_ack;
    logic              r_err;

    logic [NUM_CAND-1:0] w_v;
    logic                w_one;
    logic                w_multi;
    logic [SEL_W-1:0]    w_idx;
    logic                w_inc;
    logic                w_ack_n;
    logic                w_err_n;
    logic [CNT_W-1:0]    w_max;
    logic [SEL_W-1:0]    w_win;
    logic [4:0]          w_nmax;
    logic                w_tie;

    // A press qualifies exactly once: on the cycle its counter reaches
    // HOLD_CYC-1 while the button is still high.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            w_v[i] = button[i] & (r_q[i] == QW'(HOLD_CYC - 1));
            if (w_v[i]) w_idx = SEL_W'(i);
        end
        w_one   = (w_v != '0) && ((w_v & (w_v - 1'b1)) == '0);
        w_multi = (w_v != '0) && !w_one;
    end

    always_comb begin
        w_state_n = r_state;
        w_lock_n  = r_lock;
        w_inc     = 1'b0;
        w_ack_n   = 1'b0;
        w_err_n   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!mode && w_one) begin
                    w_inc     = 1'b1;
                    w_ack_n   = 1'b1;
                    w_lock_n  = LW'(LOCK_CYC - 1);
                    w_state_n = S_LOCK;
                end else if (!mode && w_multi) begin
                    w_err_n   = 1'b1;
                    w_state_n = S_WAIT;
                end
            end
            S_LOCK: begin
                if (mode || r_lock == '0) begin
                    w_state_n = S_WAIT;
                end else begin
                    w_lock_n = r_lock - 1'b1;
                end
            end
            S_WAIT: begin
                if (button == '0) w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // Highest tally wins; strict '>' keeps the lowest index on ties.
    always_comb begin
        w_max  = r_tally[0];
        w_win  = '0;
        w_nmax = '0;
        for (int i = 1; i < NUM_CAND; i++) begin
            if (r_tally[i] > w_max) begin
                w_max = r_tally[i];
                w_win = SEL_W'(i);
            end
        end
        for (int i = 0; i < NUM_CAND; i++) begin
            if (r_tally[i] == w_max) w_nmax = w_nmax + 1'b1;
        end
        w_tie = (w_nmax >= 5'd2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_lock   <= '0;
            r_cand   <= '0;
            r_res    <= '0;
            r_winner <= '0;
            r_tie    <= 1'b0;
            r_sat    <= 1'b0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) begin
                r_q[i]     <= '0;
                r_tally[i] <= '0;
            end
        end else begin
            r_state  <= w_state_n;
            r_lock   <= w_lock_n;
            r_ack    <= w_ack_n;
            r_err    <= w_err_n;
            r_winner <= w_win;
            r_tie    <= w_tie;
            for (int i = 0; i < NUM_CAND; i++) begin
                if (mode || !button[i]) begin
                    r_q[i] <= '0;
                end else if (r_q[i] != QW'(HOLD_CYC)) begin
                    r_q[i] <= r_q[i] + 1'b1;
                end
            end
            if (w_inc) begin
                r_cand <= w_idx;
                if (r_tally[w_idx] != TMAX) begin
                    r_tally[w_idx] <= r_tally[w_idx] + 1'b1;
                end
                if (r_tally[w_idx] >= TMAX - 1'b1) r_sat <= 1'b1;
            end
            if (32'(sel) < NUM_CAND) begin
                r_res <= r_tally[sel];
            end else begin
                r_res <= '0;
            end
        end
    end

    always_comb begin
        led = '0;
        if (mode) begin
            led = r_res;
        end else if (r_state == S_LOCK) begin
            led = CNT_W'(1) << r_cand;
        end
    end

    assign vote_ack = r_ack;
    assign vote_err = r_err;
    assign winner   = r_winner;
    assign tie      = r_tie;
    assign sat      = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_voting_machine_n.sv
// Directed self-checking bench for voting_machine_n with
// NUM_CAND=4, CNT_W=8, HOLD_CYC=3, LOCK_CYC=5.
`default_nettype none

module tb_voting_machine_n;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode;
    logic [3:0] button;
    logic [1:0] sel;
    logic [7:0] led;
    logic       vote_ack;
    logic       vote_err;
    logic [1:0] winner;
    logic       tie;
    logic       sat;

    int n_vec = 0;
    int n_err = 0;
    int n_ack = 0;
    int n_rej = 0;

    voting_machine_n #(
        .NUM_CAND(4),
        .CNT_W   (8),
        .HOLD_CYC(3),
        .LOCK_CYC(5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .mode    (mode),
        .button  (button),
        .sel     (sel),
        .led     (led),
        .vote_ack(vote_ack),
        .vote_err(vote_err),
        .winner  (winner),
        .tie     (tie),
        .sat     (sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (vote_ack === 1'b1) n_ack++;
        if (vote_err === 1'b1) n_rej++;
        if (vote_ack === 1'b1 && vote_err === 1'b1) begin
            chk("ack_err_both", 32'd1, 32'd0);
        end
    endtask

    task automatic read_tally(input logic [1:0] s, input logic [7:0] exp,
                              input string tag);
        mode = 1'b1;
        sel  = s;
        tick();
        chk(tag, led, exp);
        mode = 1'b0;
        tick();
    endtask

    initial begin
        reset  = 1'b0;
        mode   = 1'b0;
        button = '0;
        sel    = '0;
        repeat (2) tick();
        chk("rst_led", led, 8'h00);
        chk("rst_ack", vote_ack, 1'b0);
        chk("rst_err", vote_err, 1'b0);
        chk("rst_tie", tie, 1'b0);
        chk("rst_sat", sat, 1'b0);
        chk("rst_win", winner, 2'd0);
        reset = 1'b1;
        tick();
        chk("rel_tie", tie, 1'b1);

        // Single vote on candidate 2.
        n_ack  = 0;
        button = 4'b0100;
        tick();
        tick();
        chk("v2_early", n_ack, 0);
        tick();
        chk("v2_ack", vote_ack, 1'b1);
        chk("v2_led0", led, 8'h04);
        chk("v2_tie_lag", tie, 1'b1);
        button = '0;
        for (int j = 1; j < 5; j++) begin
            tick();
            chk("v2_led", led, 8'h04);
            chk("v2_ack_once", vote_ack, 1'b0);
            if (j == 1) begin
                chk("v2_win", winner, 2'd2);
                chk("v2_tie", tie, 1'b0);
            end
        end
        tick();
        chk("v2_led_off", led, 8'h00);
        tick();
        read_tally(2'd2, 8'd1, "v2_tally");

        // Long hold, release one cycle, press again.
        n_ack  = 0;
        button = 4'b0010;
        repeat (20) tick();
        chk("hold_one_ack", n_ack, 1);
        button = '0;
        tick();
        button = 4'b0010;
        repeat (3) tick();
        button = '0;
        repeat (7) tick();
        chk("hold_two_ack", n_ack, 2);
        read_tally(2'd1, 8'd2, "hold_tally");

        // Simultaneous presses are rejected.
        n_ack  = 0;
        n_rej  = 0;
        button = 4'b1001;
        repeat (3) tick();
        chk("sim_err_now", vote_err, 1'b1);
        button = '0;
        repeat (3) tick();
        chk("sim_err_cnt", n_rej, 1);
        chk("sim_no_ack", n_ack, 0);
        read_tally(2'd0, 8'd0, "sim_tally0");
        read_tally(2'd3, 8'd0, "sim_tally3");

        // Short press, then press during lockout.
        n_ack  = 0;
        button = 4'b0010;
        repeat (2) tick();
        button = '0;
        repeat (2) tick();
        chk("short_no_ack", n_ack, 0);
        button = 4'b0100;
        repeat (3) tick();
        button = '0;
        tick();
        button = 4'b0010;
        repeat (3) tick();
        button = '0;
        repeat (4) tick();
        chk("lock_acks", n_ack, 1);
        read_tally(2'd1, 8'd2, "lock_tally1");
        read_tally(2'd2, 8'd2, "lock_tally2");
        chk("tie12_win", winner, 2'd1);
        chk("tie12_tie", tie, 1'b1);

        // Saturate candidate 0.
        n_ack = 0;
        for (int v = 0; v < 256; v++) begin
            button = 4'b0001;
            repeat (3) tick();
            if (v == 255) chk("sat_last_ack", vote_ack, 1'b1);
            button = '0;
            repeat (7) tick();
        end
        chk("sat_acks", n_ack, 256);
        chk("sat_flag", sat, 1'b1);
        read_tally(2'd0, 8'hFF, "sat_tally");
        chk("sat_win", winner, 2'd0);
        chk("sat_tie", tie, 1'b0);

        // Asynchronous reset in the middle of a lockout.
        button = 4'b1000;
        repeat (3) tick();
        chk("pre_rst_led", led, 8'h08);
        #2 reset = 1'b0;
        #1;
        chk("arst_led", led, 8'h00);
        chk("arst_ack", vote_ack, 1'b0);
        chk("arst_sat", sat, 1'b0);
        chk("arst_tie", tie, 1'b0);
        button = '0;
        reset  = 1'b1;
        tick();
        chk("arst_tie1", tie, 1'b1);
        chk("arst_win", winner, 2'd0);
        read_tally(2'd0, 8'd0, "arst_tally0");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
